// File: rtl/dynamic_output_arbiter_if.sv
// Link bundle between the router input queues, one output scheduler and its downstream port.
// Handshake: the arbiter pops queue i by asserting grant[i] in the same cycle req_valid[i] is high;
// downstream consumes every cycle validOut is high and returns one yummyIn pulse per freed buffer slot.
interface dynamic_output_arbiter_if #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CW         = 3
);
    logic [NUM_IN-1:0]            req_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] req_data;
    logic [NUM_IN-1:0]            grant;
    logic [DATA_WIDTH-1:0]        dataOut;
    logic                         validOut;
    logic                         yummyIn;
    logic                         busy;
    logic [CW-1:0]                credit_cnt;
    logic                         credit_err;

    modport master (
        input  req_valid, req_data, yummyIn,
        output grant, dataOut, validOut, busy, credit_cnt, credit_err
    );

    modport slave (
        output req_valid, req_data, yummyIn,
        input  grant, dataOut, validOut, busy, credit_cnt, credit_err
    );
endinterface

// File: rtl/dynamic_output_arbiter.sv
// Output-port scheduler: packet-level round-robin with wormhole locking and
// valid/yummy credit flow control onto a single registered output link.
module dynamic_output_arbiter #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 4,
    parameter int LEN_MSB    = 29,
    parameter int LEN_LSB    = 22,
    parameter int CW         = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dynamic_output_arbiter_if.master   link,
    output logic                       stateDbg
);
    localparam int IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    state_t                state;
    state_t                stateNext;
    logic [IW-1:0]         lastWinner;
    logic [IW-1:0]         lockIdx;
    logic [IW-1:0]         winIdx;
    logic [IW-1:0]         srcIdx;
    logic                  winFound;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      hdrLen;
    logic [DATA_WIDTH-1:0] srcData;
    logic [NUM_IN-1:0]     grantVec;
    logic                  anyGrant;
    logic                  sendOk;
    logic [CW-1:0]         creditCnt;
    logic                  creditErr;
    logic [DATA_WIDTH-1:0] dataReg;
    logic                  validReg;

    assign sendOk = (creditCnt != '0);

    // Rotating priority: first requester strictly after the previous packet's winner.
    always_comb begin
        int cand;
        logic [IW-1:0] candIdx;
        cand     = 0;
        candIdx  = '0;
        winFound = 1'b0;
        winIdx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = int'(lastWinner) + k;
            if (cand >= NUM_IN) cand = cand - NUM_IN;
            candIdx = IW'(cand);
            if (!winFound && link.req_valid[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (anyGrant && hdrLen != '0)              stateNext = BODY;
            BODY: if (anyGrant && remaining == LEN_W'(1))    stateNext = IDLE;
            default:                                         stateNext = IDLE;
        endcase
    end

    // Output logic: grant is gated by reset so nothing is popped while it is held.
    always_comb begin
        grantVec = '0;
        srcIdx   = (state == BODY) ? lockIdx : winIdx;
        if (rst_n && sendOk) begin
            if (state == IDLE) begin
                if (winFound) grantVec[winIdx] = 1'b1;
            end else if (link.req_valid[lockIdx]) begin
                grantVec[lockIdx] = 1'b1;
            end
        end
    end

    assign anyGrant = |grantVec;
    assign srcData  = link.req_data[srcIdx*DATA_WIDTH +: DATA_WIDTH];
    assign hdrLen   = srcData[LEN_MSB:LEN_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastWinner <= IW'(NUM_IN - 1);
            lockIdx    <= '0;
            remaining  <= '0;
            dataReg    <= '0;
            validReg   <= 1'b0;
        end else begin
            validReg <= anyGrant;
            if (anyGrant) begin
                dataReg <= srcData;
                if (state == IDLE) begin
                    if (hdrLen == '0) begin
                        lastWinner <= winIdx;
                    end else begin
                        lockIdx   <= winIdx;
                        remaining <= hdrLen;
                    end
                end else begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) lastWinner <= lockIdx;
                end
            end
        end
    end

    // Credits: a send and a returned credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            creditCnt <= CW'(CREDITS);
            creditErr <= 1'b0;
        end else if (link.yummyIn && !anyGrant && creditCnt == CW'(CREDITS)) begin
            creditErr <= 1'b1;
        end else if (anyGrant && !link.yummyIn) begin
            creditCnt <= creditCnt - 1'b1;
        end else if (!anyGrant && link.yummyIn) begin
            creditCnt <= creditCnt + 1'b1;
        end
    end

    assign link.grant      = grantVec;
    assign link.dataOut    = dataReg;
    assign link.validOut   = validReg;
    assign link.busy       = (state == BODY);
    assign link.credit_cnt = creditCnt;
    assign link.credit_err = creditErr;
    assign stateDbg        = (state == BODY);
endmodule

// File: tb/tb_dynamic_output_arbiter.sv
// Bench for dynamic_output_arbiter: directed scenarios with spec constants plus
// randomized traffic checked against a packet-level reference model.
module tb_dynamic_output_arbiter;
    localparam int NUM_IN  = 5;
    localparam int DW      = 64;
    localparam int CREDITS = 4;
    localparam int LEN_MSB = 29;
    localparam int LEN_LSB = 22;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int CW      = 3;

    logic clk;
    logic rst_n;
    logic stateDbg;
    int   passCnt;
    int   totalCnt;

    // Reference model state
    int          mLast, mLock, mRem, mCred;
    bit          mBody, mErr, mValid;
    logic [DW-1:0] mData;
    logic [DW-1:0] exp_q[$];

    dynamic_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .CW(CW)) bus ();

    dynamic_output_arbiter #(
        .NUM_IN(NUM_IN), .DATA_WIDTH(DW), .CREDITS(CREDITS),
        .LEN_MSB(LEN_MSB), .LEN_LSB(LEN_LSB), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link(bus.master), .stateDbg(stateDbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk_flit(input int len);
        logic [DW-1:0] f;
        f = {$urandom(), $urandom()};
        f[LEN_MSB:LEN_LSB] = LEN_W'(len);
        return f;
    endfunction

    task automatic set_flit(input int i, input logic [DW-1:0] f);
        bus.req_data[i*DW +: DW] = f;
    endtask

    function automatic logic [DW-1:0] get_flit(input int i);
        return bus.req_data[i*DW +: DW];
    endfunction

    function automatic logic [NUM_IN-1:0] model_grant();
        logic [NUM_IN-1:0] g;
        g = '0;
        if (rst_n !== 1'b1 || mCred == 0) return g;
        if (mBody) begin
            if (bus.req_valid[mLock]) g[mLock] = 1'b1;
            return g;
        end
        for (int k = 1; k <= NUM_IN; k++) begin
            int c;
            c = (mLast + k) % NUM_IN;
            if (bus.req_valid[c]) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        mLast = NUM_IN - 1; mLock = 0; mRem = 0; mCred = CREDITS;
        mBody = 0; mErr = 0; mValid = 0; mData = '0;
        exp_q.delete();
    endtask

    // Advance one clock and apply the packet rules to the model.
    task automatic tick();
        logic [NUM_IN-1:0] g;
        logic [DW-1:0] f;
        int idx, len;
        @(posedge clk);
        g = model_grant();
        if (g != '0) begin
            idx = 0;
            for (int i = 0; i < NUM_IN; i++) if (g[i]) idx = i;
            f = get_flit(idx);
            len = int'(f[LEN_MSB:LEN_LSB]);
            mValid = 1; mData = f;
            exp_q.push_back(f);
            if (!mBody) begin
                if (len == 0) mLast = idx;
                else begin mBody = 1; mLock = idx; mRem = len; end
            end else begin
                mRem = mRem - 1;
                if (mRem == 0) begin mBody = 0; mLast = mLock; end
            end
        end else begin
            mValid = 0;
        end
        if (bus.yummyIn && g == '0 && mCred == CREDITS) mErr = 1;
        else mCred = mCred - ((g != '0) ? 1 : 0) + (bus.yummyIn ? 1 : 0);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.yummyIn   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            totalCnt++; if (bus.grant !== '0) $display("FAIL reset_grant: got %0h want 0", bus.grant); else passCnt++;
            totalCnt++; if (bus.validOut !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.validOut); else passCnt++;
            totalCnt++; if (bus.credit_cnt !== 3'd4) $display("FAIL reset_credit: got %0d want 4", bus.credit_cnt); else passCnt++;
            totalCnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passCnt++;
            tick();
        end
        totalCnt++; if (bus.dataOut !== '0 || bus.credit_err !== 1'b0)
            $display("FAIL reset_data_err: got data %0h err %0b want 0 0", bus.dataOut, bus.credit_err); else passCnt++;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] prevFlit;
        logic [NUM_IN-1:0] e;
        int idx;
        do_reset();
        prevFlit = '0;
        for (int c = 0; c < 8; c++) begin
            set_flit(0, mk_flit(0));
            set_flit(3, mk_flit(0));
            bus.req_valid = 5'b01001;
            bus.yummyIn = mValid;
            @(negedge clk);
            idx = (c % 2 == 0) ? 0 : 3;
            e = '0; e[idx] = 1'b1;
            totalCnt++; if (bus.grant !== e) $display("FAIL rr_grant: cycle %0d got %0h want %0h", c, bus.grant, e); else passCnt++;
            if (c > 0) begin
                totalCnt++; if (bus.validOut !== 1'b1 || bus.dataOut !== prevFlit)
                    $display("FAIL rr_data: cycle %0d got %0b/%0h want 1/%0h", c, bus.validOut, bus.dataOut, prevFlit); else passCnt++;
            end
            prevFlit = get_flit(idx);
            tick();
        end
    endtask

    task automatic test_wormhole();
        int vTab[13] = '{2, 6, 6, 6, 6, 6, 6, 6, 2, 2, 6, 6, 6};
        int gTab[13] = '{1, 2, 2, 2, 2, 1, 2, 2, -1, -1, 2, 2, 1};
        bit bTab[13] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        logic [NUM_IN-1:0] e;
        logic [DW-1:0] prevFlit;
        bit prevSent;
        do_reset();
        prevSent = 0; prevFlit = '0;
        for (int c = 0; c < 13; c++) begin
            bus.req_valid = NUM_IN'(vTab[c]);
            set_flit(1, mk_flit(0));
            set_flit(2, (c == 1 || c == 6) ? mk_flit(3) : mk_flit(int'($urandom_range(0, 255))));
            bus.yummyIn = mValid;
            @(negedge clk);
            e = '0;
            if (gTab[c] >= 0) e[gTab[c]] = 1'b1;
            totalCnt++; if (bus.grant !== e) $display("FAIL wh_grant: cycle %0d got %0h want %0h", c, bus.grant, e); else passCnt++;
            totalCnt++; if (bus.busy !== bTab[c]) $display("FAIL wh_busy: cycle %0d got %0b want %0b", c, bus.busy, bTab[c]); else passCnt++;
            totalCnt++; if (bus.validOut !== prevSent || (prevSent && bus.dataOut !== prevFlit))
                $display("FAIL wh_out: cycle %0d got %0b/%0h want %0b/%0h", c, bus.validOut, bus.dataOut, prevSent, prevFlit); else passCnt++;
            prevSent = (gTab[c] >= 0);
            if (prevSent) prevFlit = get_flit(gTab[c]);
            tick();
        end
    endtask

    task automatic test_credit_exhaust();
        logic [NUM_IN-1:0] e;
        do_reset();
        bus.req_valid = 5'b10000;
        for (int c = 0; c < 9; c++) begin
            set_flit(4, mk_flit(0));
            bus.yummyIn = (c == 6);
            @(negedge clk);
            e = (c < 4 || c == 7) ? 5'b10000 : 5'b00000;
            totalCnt++; if (bus.grant !== e) $display("FAIL cr_grant: cycle %0d got %0h want %0h", c, bus.grant, e); else passCnt++;
            totalCnt++;
            if (bus.credit_cnt !== CW'((c < 4) ? 4 - c : (c == 7 ? 1 : 0)))
                $display("FAIL cr_count: cycle %0d got %0d", c, bus.credit_cnt); else passCnt++;
            tick();
        end
    endtask

    task automatic test_credit_edge();
        do_reset();
        bus.req_valid = 5'b00001;
        for (int c = 0; c < 2; c++) begin set_flit(0, mk_flit(0)); tick(); end
        set_flit(0, mk_flit(0));
        bus.yummyIn = 1'b1;
        @(negedge clk);
        totalCnt++; if (bus.credit_cnt !== 3'd2 || bus.grant !== 5'b00001)
            $display("FAIL ce_pre: got %0d/%0h want 2/1", bus.credit_cnt, bus.grant); else passCnt++;
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            totalCnt++; if (bus.credit_cnt !== CW'(2 + c)) $display("FAIL ce_count: step %0d got %0d want %0d", c, bus.credit_cnt, 2 + c); else passCnt++;
            totalCnt++; if (bus.credit_err !== 1'b0) $display("FAIL ce_noerr: step %0d got %0b want 0", c, bus.credit_err); else passCnt++;
            tick();
        end
        bus.yummyIn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            totalCnt++; if (bus.credit_err !== 1'b1 || bus.credit_cnt !== 3'd4)
                $display("FAIL ce_err: step %0d got %0b/%0d want 1/4", c, bus.credit_err, bus.credit_cnt); else passCnt++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_valid = 5'b00100;
        set_flit(2, mk_flit(5));
        tick();
        for (int c = 0; c < 2; c++) begin set_flit(2, mk_flit(int'($urandom_range(0, 255)))); tick(); end
        @(negedge clk);
        totalCnt++; if (bus.busy !== 1'b1 || bus.grant !== 5'b00100)
            $display("FAIL ar_pre: got busy %0b grant %0h want 1/4", bus.busy, bus.grant); else passCnt++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        totalCnt++; if (bus.busy !== 1'b0) $display("FAIL ar_busy: got %0b want 0", bus.busy); else passCnt++;
        totalCnt++; if (bus.validOut !== 1'b0) $display("FAIL ar_valid: got %0b want 0", bus.validOut); else passCnt++;
        totalCnt++; if (bus.grant !== '0) $display("FAIL ar_grant: got %0h want 0", bus.grant); else passCnt++;
        totalCnt++; if (bus.credit_cnt !== 3'd4) $display("FAIL ar_credit: got %0d want 4", bus.credit_cnt); else passCnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.req_valid = 5'b11111;
        for (int i = 0; i < NUM_IN; i++) set_flit(i, mk_flit(0));
        @(negedge clk);
        totalCnt++; if (bus.grant !== 5'b00001) $display("FAIL ar_first: got %0h want 1", bus.grant); else passCnt++;
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NUM_IN'($urandom_range(0, (1 << NUM_IN) - 1));
            for (int i = 0; i < NUM_IN; i++)
                set_flit(i, mk_flit(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3))));
            bus.yummyIn = (mCred < CREDITS) && ($urandom_range(0, 2) != 0);
            @(negedge clk);
            totalCnt++; if (bus.grant !== model_grant()) $display("FAIL rnd_grant: cycle %0d got %0h want %0h", c, bus.grant, model_grant()); else passCnt++;
            totalCnt++; if (bus.busy !== mBody || bus.credit_cnt !== CW'(mCred) || bus.credit_err !== mErr)
                $display("FAIL rnd_state: cycle %0d got %0b/%0d/%0b want %0b/%0d/%0b", c, bus.busy, bus.credit_cnt, bus.credit_err, mBody, mCred, mErr); else passCnt++;
            totalCnt++; if (bus.validOut !== mValid) $display("FAIL rnd_valid: cycle %0d got %0b want %0b", c, bus.validOut, mValid); else passCnt++;
            if (bus.validOut === 1'b1) begin
                totalCnt++;
                if (exp_q.size() == 0) $display("FAIL rnd_data: cycle %0d unexpected flit %0h", c, bus.dataOut);
                else begin
                    exp = exp_q.pop_front();
                    if (bus.dataOut !== exp) $display("FAIL rnd_data: cycle %0d got %0h want %0h", c, bus.dataOut, exp);
                    else passCnt++;
                end
            end
            tick();
        end
    endtask

    initial begin
        passCnt = 0;
        totalCnt = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.yummyIn = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_credit_edge();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
